// File: rtl/breakout_pkg.sv
// Shared Breakout definitions: lives FSM states and default game tuning constants.
package breakout_pkg;

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    RESPAWN = 2'd1,
    DEAD    = 2'd2
  } lives_state_t;

  localparam int DEFAULT_MAX_LIVES      = 5;
  localparam int DEFAULT_START_LIVES    = 3;
  localparam int DEFAULT_RESPAWN_FRAMES = 60;

endpackage

// File: rtl/rising_edge_detect.sv
// Single-cycle pulse on each rising edge of a level input; the history register's
// reset value decides whether a level held through reset is seen as an edge.
module rising_edge_detect #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out_pulse
);

  logic in_q;

  // History register samples the input every cycle regardless of consumer state.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_q <= RESET_VALUE;
    end else begin
      in_q <= in;
    end
  end

  assign out_pulse = in & ~in_q;

endmodule

// File: rtl/lives_manager.sv
// Breakout player-lives tracker: counts lives, awards capped bonuses, times the
// respawn after a loss and latches game-over until a new game is requested.
module lives_manager
  import breakout_pkg::*;
#(
  parameter int MAX_LIVES      = DEFAULT_MAX_LIVES,
  parameter int START_LIVES    = DEFAULT_START_LIVES,
  parameter int RESPAWN_FRAMES = DEFAULT_RESPAWN_FRAMES,
  localparam int LW = $clog2(MAX_LIVES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_tick,
  input  logic          ball_lost,
  input  logic          bonus_life,
  input  logic          new_game,
  output logic [LW-1:0] lives,
  output logic          serving,
  output logic          game_over,
  output logic          life_lost
);

  localparam int TW = $clog2(RESPAWN_FRAMES + 1);

  localparam logic [LW-1:0] MAX_L   = LW'(MAX_LIVES);
  localparam logic [LW-1:0] START_L = LW'(START_LIVES);
  localparam logic [TW-1:0] RESP_T  = TW'(RESPAWN_FRAMES);

  lives_state_t  state;
  logic [TW-1:0] timer;
  logic          lost_edge;

  // History starts at 1 so a ball_lost level held through reset is not a loss.
  rising_edge_detect #(
    .RESET_VALUE(1'b1)
  ) u_lost_edge (
    .clk      (clk),
    .reset    (reset),
    .in       (ball_lost),
    .out_pulse(lost_edge)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= PLAY;
      lives     <= START_L;
      timer     <= '0;
      serving   <= 1'b0;
      game_over <= 1'b0;
      life_lost <= 1'b0;
    end else begin
      life_lost <= 1'b0;
      if (new_game) begin
        state     <= RESPAWN;
        lives     <= START_L;
        timer     <= RESP_T;
        serving   <= 1'b1;
        game_over <= 1'b0;
      end else begin
        case (state)
          PLAY: begin
            if (lost_edge) begin
              life_lost <= 1'b1;
              if (bonus_life) begin
                // Loss and bonus in the same cycle cancel; the ball still respawns.
                state   <= RESPAWN;
                timer   <= RESP_T;
                serving <= 1'b1;
              end else if (lives <= LW'(1)) begin
                lives     <= '0;
                state     <= DEAD;
                game_over <= 1'b1;
              end else begin
                lives   <= lives - LW'(1);
                state   <= RESPAWN;
                timer   <= RESP_T;
                serving <= 1'b1;
              end
            end else if (bonus_life && (lives < MAX_L)) begin
              lives <= lives + LW'(1);
            end
          end

          RESPAWN: begin
            if (bonus_life && (lives < MAX_L)) begin
              lives <= lives + LW'(1);
            end
            if (frame_tick) begin
              if (timer <= TW'(1)) begin
                timer   <= '0;
                state   <= PLAY;
                serving <= 1'b0;
              end else begin
                timer <= timer - TW'(1);
              end
            end
          end

          DEAD: begin
            lives     <= '0;
            game_over <= 1'b1;
            serving   <= 1'b0;
          end

          default: begin
            state     <= PLAY;
            serving   <= 1'b0;
            game_over <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lives_manager.sv
// Self-checking bench for lives_manager: directed game scenarios followed by random
// traffic, every cycle compared against a mode/count reference model.
module tb_lives_manager;

  localparam int MAX_LIVES      = 5;
  localparam int START_LIVES    = 3;
  localparam int RESPAWN_FRAMES = 2;
  localparam int LW             = $clog2(MAX_LIVES + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_tick;
  logic          ball_lost;
  logic          bonus_life;
  logic          new_game;
  logic [LW-1:0] lives;
  logic          serving;
  logic          game_over;
  logic          life_lost;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: game mode as text, plain integer counts.
  string m_mode;
  int    m_lives;
  int    m_frames_left;
  bit    m_life_lost;
  bit    m_prev_lost;

  always #5 clk = ~clk;

  lives_manager #(
    .MAX_LIVES     (MAX_LIVES),
    .START_LIVES   (START_LIVES),
    .RESPAWN_FRAMES(RESPAWN_FRAMES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .frame_tick(frame_tick),
    .ball_lost (ball_lost),
    .bonus_life(bonus_life),
    .new_game  (new_game),
    .lives     (lives),
    .serving   (serving),
    .game_over (game_over),
    .life_lost (life_lost)
  );

  task automatic modelStep(input bit rst, input bit bl, input bit bn, input bit ng, input bit ft);
    bit lost_now;
    lost_now    = bl && !m_prev_lost;
    m_prev_lost = bl;
    m_life_lost = 0;
    if (rst) begin
      m_mode        = "play";
      m_lives       = START_LIVES;
      m_frames_left = 0;
      m_prev_lost   = 1;
    end else if (ng) begin
      m_mode        = "respawn";
      m_lives       = START_LIVES;
      m_frames_left = RESPAWN_FRAMES;
    end else if (m_mode == "play") begin
      if (lost_now) begin
        m_life_lost = 1;
        if (!bn) m_lives = m_lives - 1;
        if (m_lives == 0) begin
          m_mode = "dead";
        end else begin
          m_mode        = "respawn";
          m_frames_left = RESPAWN_FRAMES;
        end
      end else if (bn) begin
        m_lives = (m_lives + 1 > MAX_LIVES) ? MAX_LIVES : m_lives + 1;
      end
    end else if (m_mode == "respawn") begin
      if (bn) m_lives = (m_lives + 1 > MAX_LIVES) ? MAX_LIVES : m_lives + 1;
      if (ft) begin
        m_frames_left = m_frames_left - 1;
        if (m_frames_left == 0) m_mode = "play";
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [LW-1:0] exp_lives;
    logic          exp_serving;
    logic          exp_over;
    logic          exp_lost;
    exp_lives   = LW'(m_lives);
    exp_serving = (m_mode == "respawn");
    exp_over    = (m_mode == "dead");
    exp_lost    = m_life_lost;
    compared++;
    assert (lives === exp_lives) else begin
      mismatched++;
      $error("[TB] FAIL %s lives: observed %0d expected %0d", tag, lives, exp_lives);
    end
    compared++;
    assert (serving === exp_serving) else begin
      mismatched++;
      $error("[TB] FAIL %s serving: observed %b expected %b", tag, serving, exp_serving);
    end
    compared++;
    assert (game_over === exp_over) else begin
      mismatched++;
      $error("[TB] FAIL %s game_over: observed %b expected %b", tag, game_over, exp_over);
    end
    compared++;
    assert (life_lost === exp_lost) else begin
      mismatched++;
      $error("[TB] FAIL %s life_lost: observed %b expected %b", tag, life_lost, exp_lost);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare 1 ns later.
  task automatic applyStimulus(input string tag, input bit rst, input bit bl,
                               input bit bn, input bit ng, input bit ft);
    reset      = rst;
    ball_lost  = bl;
    bonus_life = bn;
    new_game   = ng;
    frame_tick = ft;
    @(posedge clk);
    modelStep(rst, bl, bn, ng, ft);
    #1;
    checkOutput(tag);
  endtask

  task automatic loseLife(input string tag);
    applyStimulus(tag, 0, 0, 0, 0, 0);
    applyStimulus(tag, 0, 1, 0, 0, 0);
    applyStimulus(tag, 0, 0, 0, 0, 1);
    applyStimulus(tag, 0, 0, 0, 0, 1);
    applyStimulus(tag, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit bl_level;
    m_mode = "play"; m_lives = START_LIVES; m_frames_left = 0;
    m_life_lost = 0; m_prev_lost = 1;

    // Reset with ball_lost held high, then keep it high: no loss may be counted.
    applyStimulus("reset_hold", 1, 1, 0, 0, 0);
    applyStimulus("reset_hold", 1, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus("held_level", 0, 1, 0, 0, 0);

    // Three losses run the game down to DEAD.
    loseLife("loss1");
    loseLife("loss2");
    loseLife("loss3");

    applyStimulus("dead_bonus", 0, 0, 1, 0, 0);
    applyStimulus("dead_lost", 0, 1, 0, 0, 0);
    applyStimulus("dead_lost", 0, 0, 0, 0, 0);
    applyStimulus("new_game", 0, 0, 0, 1, 0);
    applyStimulus("ng_tick", 0, 0, 0, 0, 1);
    applyStimulus("ng_tick", 0, 0, 0, 0, 1);
    applyStimulus("ng_play", 0, 0, 0, 0, 0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus("bonus_sat", 0, 0, 1, 0, 0);
      applyStimulus("bonus_sat", 0, 0, 0, 0, 0);
    end
    applyStimulus("loss_bonus_max", 0, 1, 1, 0, 0);
    applyStimulus("loss_bonus_max", 0, 0, 0, 0, 1);
    applyStimulus("loss_bonus_max", 0, 0, 0, 0, 1);

    for (int i = 0; i < 4; i++) loseLife("to_one");
    applyStimulus("loss_bonus_one", 0, 1, 1, 0, 0);
    applyStimulus("respawn_ignore", 0, 0, 0, 0, 0);
    applyStimulus("respawn_ignore", 0, 1, 0, 0, 0);
    applyStimulus("respawn_tick", 0, 1, 0, 0, 1);
    applyStimulus("mid_reset", 1, 0, 0, 0, 0);
    applyStimulus("after_reset", 0, 0, 0, 0, 0);
    applyStimulus("ng_with_tick", 0, 0, 0, 1, 1);
    applyStimulus("ng_tick_a", 0, 0, 0, 0, 1);
    applyStimulus("ng_tick_b", 0, 0, 0, 0, 1);
    applyStimulus("ng_done", 0, 0, 0, 0, 0);

    // Random traffic: ball_lost as a wandering level, sparse pulses elsewhere.
    bl_level = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 4) == 0) bl_level = !bl_level;
      applyStimulus("random",
                    $urandom_range(0, 99) == 0,
                    bl_level,
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 39) == 0,
                    $urandom_range(0, 2) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lives_manager.md
# lives_manager

Parametrised player-lives tracker for the Breakout game. Counts lives and awards bonus lives up to a cap. Holds the ball in a timed respawn after each loss and latches game-over until a new game is requested. Sits between the ball/paddle collision logic (ball-lost, bonus events) and the display and serve control (lives count, serving, game_over).

## Interface
- MAX_LIVES, 5: life cap; bonus lives saturate here; must be ≥1.
- START_LIVES, 3: lives loaded at reset and at new_game; range 1..MAX_LIVES.
- RESPAWN_FRAMES, 60: frame_tick pulses spent in RESPAWN after a loss or new game; must be ≥1.
- LW (derived, localparam): $clog2(MAX_LIVES+1).

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame; paces the respawn timer.
- ball_lost  in  1  level or pulse from collision logic; only its rising edge counts.
- bonus_life  in  1  one-cycle pulse; award one life.
- new_game  in  1  one-cycle pulse; restart the game.
- lives  out  LW  current life count.
- serving  out  1  high while in RESPAWN; serve logic parks the ball.
- game_over  out  1  high while in DEAD.
- life_lost  out  1  one-cycle pulse when a life is deducted.

## Operation
- States: PLAY, RESPAWN, DEAD. All outputs are registered.
- Reset: state=PLAY, lives=START_LIVES, timer=0, serving=0, game_over=0, life_lost=0.
  - Edge-detect register is loaded with 1, so a ball_lost level held through reset does not count.
- Rising edge: lost_edge = ball_lost & ~ball_lost_q. ball_lost_q samples ball_lost every cycle in all states.
- Priority, highest first: reset > new_game > loss/bonus.
- new_game in any state: lives=START_LIVES, timer=RESPAWN_FRAMES, state goes to RESPAWN. A simultaneous lost_edge or bonus_life is discarded.
- PLAY, lost_edge without bonus_life:
  - life_lost=1 for one cycle.
  - If lives==1: lives=0, state goes to DEAD.
  - Otherwise: lives-1, timer=RESPAWN_FRAMES, state goes to RESPAWN.
- PLAY, lost_edge with bonus_life: lives unchanged (net zero, even at lives==1 or lives==MAX_LIVES). life_lost=1, state goes to RESPAWN.
- PLAY or RESPAWN, bonus_life alone: lives = min(lives+1, MAX_LIVES).
- RESPAWN:
  - serving=1; lost_edge is ignored.
  - Each frame_tick decrements timer.
  - A frame_tick while timer==1 sets timer to 0 and moves the state to PLAY.
  - A ball_lost level still high on entering PLAY does not retrigger, because ball_lost_q is already 1.
- DEAD: game_over=1, lives=0. bonus_life and lost_edge are ignored; only new_game exits.
- Arithmetic is unsigned LW-bit. lives never underflows below 0 and never exceeds MAX_LIVES.

## Timing
- Latency 1: lives, state, serving, game_over and life_lost update on the clock edge that first samples ball_lost high. They are visible in the following cycle.
- life_lost is high for exactly one cycle per deduction, in the same cycle as the new lives value.
- RESPAWN length is exactly RESPAWN_FRAMES frame_tick pulses. serving falls in the cycle after the final tick.
- Reset asserted mid-RESPAWN or in DEAD takes effect at the next edge, with no residual serving or game_over.
- A frame_tick coincident with new_game does not decrement the freshly loaded timer.

## Structure
- Shared package breakout_pkg:
  - lives_state_t enum {PLAY, RESPAWN, DEAD}.
  - Default constants DEFAULT_MAX_LIVES=5, DEFAULT_START_LIVES=3, DEFAULT_RESPAWN_FRAMES=60.
- Sub-module rising_edge_detect (clk, reset, in, out_pulse; reset value of the history register set by a parameter, here 1). Reusable for paddle buttons.
- The FSM, lives counter and respawn timer stay in lives_manager. Timer width is $clog2(RESPAWN_FRAMES+1).

## Test plan
- Bench parameters: MAX_LIVES=5, START_LIVES=3, RESPAWN_FRAMES=2.
- Reset with ball_lost held 1, then release: lives=3, state PLAY, no life_lost; hold ball_lost 1 for 10 cycles: still lives=3.
- Three ball_lost edges, each separated by 2 frame_ticks: lives goes 2, 1, 0. life_lost pulses 3 times, serving high for each 2-tick window, game_over=1 after the third loss.
- In DEAD, pulse bonus_life and ball_lost: no change. Pulse new_game: lives=3, serving=1, game_over=0. After 2 frame_ticks: serving=0.
- From lives=3, issue 4 bonus_life pulses: lives saturates at 5. Then ball_lost together with bonus_life: lives stays 5, life_lost=1, state RESPAWN.
- At lives=1, ball_lost together with bonus_life: lives=1, state RESPAWN, not DEAD. ball_lost edge during RESPAWN: ignored.
- Mid-RESPAWN (timer=1), assert reset: next cycle lives=3, serving=0, state PLAY. frame_tick together with new_game: RESPAWN still needs 2 further ticks.
